// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared memory-interface encodings and fetch FSM states
package fetch_sequencer_pkg;
  localparam logic ENABLE = 1'b1;
  localparam logic DISABLE = 1'b0;
  localparam logic READ = 1'b0;
  localparam logic [3:0] FULL_FRAME = 4'b1111;
  typedef enum logic [1:0] {
    FETCH_ISSUE   = 2'd0,
    FETCH_WAIT    = 2'd1,
    FETCH_DISCARD = 2'd2
  } fetch_state_t;
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: registered FIFO of {pc, word} pairs between fetch and decode
// Ports: clk/reset (async active-low), push/push_data, pop, flush (clears and
// overrides same-cycle push/pop), count, head_valid/head_data (combinational).
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     head_valid,
  output logic [WIDTH-1:0]         head_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_pop;
  assign head_valid = count != '0;
  assign head_data = head_valid ? mem[rd_ptr] : '0;
  assign do_pop = pop && head_valid;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      rd_ptr <= rd_ptr + AW'(do_pop);
      wr_ptr <= wr_ptr + AW'(push);
      count <= count + CW'(push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (push && !flush) mem[wr_ptr] <= push_data;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, issues word fetches and queues returned words
// Ports: clk, reset (async active-low); memory_interface_* request/response
// side (one outstanding READ); redirect_valid/redirect_address flush and
// restart; instruction_valid/instruction/instruction_pc/instruction_ready
// present the queue head to decode.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_ADDRESS = 32'h0000_0000,
  parameter int          QUEUE_DEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        memory_interface_enable,
  output logic        memory_interface_state,
  output logic [31:0] memory_interface_address,
  output logic [3:0]  memory_interface_frame_mask,
  input  logic        memory_interface_ready,
  input  logic        memory_interface_valid,
  input  logic [31:0] memory_interface_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_address,
  output logic        instruction_valid,
  output logic [31:0] instruction,
  output logic [31:0] instruction_pc,
  input  logic        instruction_ready
);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  fetch_state_t state, state_next;
  logic [31:0] pc, req_pc;
  logic [CW-1:0] count;
  logic accept, push;
  assign memory_interface_state = READ;
  assign memory_interface_frame_mask = FULL_FRAME;
  assign memory_interface_address = pc;
  assign accept = memory_interface_enable && memory_interface_ready;
  assign push = state == FETCH_WAIT && memory_interface_valid && !redirect_valid;
  // count MSB set means full, since the count never exceeds the power-of-two depth.
  // Gating with reset keeps enable low while reset is held even though state already reads ISSUE.
  always_comb begin
    memory_interface_enable = (reset && state == FETCH_ISSUE && !count[CW-1]) ? ENABLE : DISABLE;
    state_next = state == FETCH_ISSUE ? (accept ? (redirect_valid ? FETCH_DISCARD : FETCH_WAIT) : FETCH_ISSUE)
               : memory_interface_valid ? FETCH_ISSUE
               : redirect_valid ? FETCH_DISCARD : state;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= FETCH_ISSUE;
      pc <= RESET_ADDRESS;
      req_pc <= RESET_ADDRESS;
    end else begin
      state <= state_next;
      pc <= redirect_valid ? word_align(redirect_address) : accept ? {pc[31:2] + 30'd1, 2'b00} : pc;
      if (accept) req_pc <= pc;
    end
  fetch_queue #(.DEPTH(QUEUE_DEPTH), .WIDTH(64)) u_queue (
    .clk(clk),
    .reset(reset),
    .push(push),
    .push_data({req_pc, memory_interface_data}),
    .pop(instruction_valid && instruction_ready),
    .flush(redirect_valid),
    .count(count),
    .head_valid(instruction_valid),
    .head_data({instruction_pc, instruction})
  );
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed and randomized checks of fetch_sequencer against a transaction-level model
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;
  localparam int DEPTH = 2;
  logic clk = 0, reset = 0;
  logic en, st;
  logic [31:0] addr;
  logic [3:0] mask;
  logic ready = 0, mem_valid = 0;
  logic [31:0] mem_data = 0;
  logic redirect = 0;
  logic [31:0] redirect_address = 0;
  logic iv, iready = 0;
  logic [31:0] inst, ipc;
  int tests = 0, fails = 0;
  bit mem_busy = 0;
  int mem_delay = 0, mem_lat = 0;
  logic [31:0] mem_addr = 0;
  logic [63:0] m_q[$];
  logic [31:0] m_pc = 0, m_req = 0;
  bit m_out = 0, m_stale = 0;
  logic s_en, s_iv, e_en, e_iv;
  logic [31:0] s_addr, s_inst, s_ipc, e_addr, e_inst, e_ipc;
  always #5 clk = ~clk;
  fetch_sequencer #(.RESET_ADDRESS(32'h0), .QUEUE_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .memory_interface_enable(en), .memory_interface_state(st),
    .memory_interface_address(addr), .memory_interface_frame_mask(mask),
    .memory_interface_ready(ready), .memory_interface_valid(mem_valid),
    .memory_interface_data(mem_data),
    .redirect_valid(redirect), .redirect_address(redirect_address),
    .instruction_valid(iv), .instruction(inst), .instruction_pc(ipc),
    .instruction_ready(iready)
  );
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h13;
  endfunction
  task automatic model_reset();
    m_q.delete();
    m_pc = 32'h0;
    m_out = 0;
    m_stale = 0;
    mem_busy = 0;
    mem_valid = 0;
  endtask
  // One cycle: drive memory response, snapshot DUT and model, advance both at the edge.
  task automatic tick();
    bit acc, mem_acc, pop, mv;
    mem_valid = mem_busy && mem_delay == 0;
    mem_data = mem_valid ? word_of(mem_addr) : $urandom;
    #1;
    s_en = en; s_addr = addr; s_iv = iv; s_inst = inst; s_ipc = ipc;
    e_en = !m_out && m_q.size() < DEPTH;
    e_addr = m_pc;
    e_iv = m_q.size() != 0;
    {e_ipc, e_inst} = e_iv ? m_q[0] : 64'h0;
    acc = e_en && ready;
    mem_acc = s_en && ready;
    pop = e_iv && iready;
    mv = mem_valid;
    @(posedge clk);
    if (mv) mem_busy = 0;
    else if (mem_busy) mem_delay--;
    if (mem_acc) begin mem_busy = 1; mem_delay = mem_lat; mem_addr = s_addr; end
    if (redirect) begin
      m_q.delete();
      m_pc = {redirect_address[31:2], 2'b00};
      if (mv) m_out = 0;
      if (acc) m_out = 1;
      m_stale = m_out;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (mv && m_out) begin
        if (!m_stale) m_q.push_back({m_req, word_of(m_req)});
        m_out = 0;
      end
      if (acc) begin m_out = 1; m_stale = 0; m_req = m_pc; m_pc = m_pc + 32'd4; end
    end
    @(negedge clk);
  endtask
  task automatic settle(input logic [31:0] a);
    ready = 0; iready = 0; redirect = 1; redirect_address = a;
    tick();
    redirect = 0;
    for (int i = 0; i < 16 && m_out; i++) tick();
  endtask
  task automatic test_reset();
    #2;
    tests++; if (en !== 1'b0) begin fails++; $display("FAIL reset_enable got %b want 0", en); end
    tests++; if (st !== READ || mask !== 4'hF) begin fails++; $display("FAIL reset_state_mask got %b/%h want %b/f", st, mask, READ); end
    tests++; if (addr !== 32'h0) begin fails++; $display("FAIL reset_address got %h want 0", addr); end
    tests++; if ({iv, inst, ipc} !== 65'h0) begin fails++; $display("FAIL reset_head got %b %h %h want 0", iv, inst, ipc); end
    @(negedge clk); @(negedge clk);
    reset = 1;
    model_reset();
  endtask
  task automatic test_latency();
    ready = 1; iready = 1; mem_lat = 0;
    tick();
    tests++; if (s_en !== 1'b1 || s_addr !== 32'h0) begin fails++; $display("FAIL lat_c0 got en=%b addr=%h want 1/0", s_en, s_addr); end
    tick();
    tests++; if (s_en !== 1'b0 || s_iv !== 1'b0) begin fails++; $display("FAIL lat_c1 got en=%b iv=%b want 0/0", s_en, s_iv); end
    tick();
    tests++; if (s_iv !== 1'b1 || s_ipc !== 32'h0 || s_inst !== 32'h13) begin fails++; $display("FAIL lat_c2_head got iv=%b pc=%h inst=%h want 1/0/13", s_iv, s_ipc, s_inst); end
    tests++; if (s_en !== 1'b1 || s_addr !== 32'h4) begin fails++; $display("FAIL lat_c2_req got en=%b addr=%h want 1/4", s_en, s_addr); end
    tick(); tick();
    tests++; if (s_en !== 1'b1 || s_addr !== 32'h8) begin fails++; $display("FAIL lat_c4_req got en=%b addr=%h want 1/8", s_en, s_addr); end
  endtask
  task automatic test_backpressure();
    settle(32'h0);
    ready = 1; iready = 0; mem_lat = 0;
    for (int i = 0; i < 6; i++) tick();
    tests++; if (en !== 1'b0 || iv !== 1'b1 || ipc !== 32'h0) begin fails++; $display("FAIL bp_full got en=%b iv=%b pc=%h want 0/1/0", en, iv, ipc); end
    tick();
    tests++; if (s_en !== 1'b0) begin fails++; $display("FAIL bp_hold got en=%b want 0", s_en); end
    iready = 1;
    tick();
    tests++; if (s_iv !== 1'b1 || s_ipc !== 32'h0 || s_en !== 1'b0) begin fails++; $display("FAIL bp_pop0 got iv=%b pc=%h en=%b want 1/0/0", s_iv, s_ipc, s_en); end
    tick();
    tests++; if (s_ipc !== 32'h4 || s_inst !== word_of(32'h4) || s_en !== 1'b1 || s_addr !== 32'h8) begin fails++; $display("FAIL bp_pop1 got pc=%h inst=%h en=%b addr=%h want 4/%h/1/8", s_ipc, s_inst, s_en, s_addr, word_of(32'h4)); end
  endtask
  task automatic test_redirect_wait();
    int n;
    settle(32'h0);
    ready = 1; iready = 1; mem_lat = 1;
    tick();
    redirect = 1; redirect_address = 32'h0000_1002;
    tick();
    redirect = 0;
    tick();
    tests++; if (s_en !== 1'b0 || s_iv !== 1'b0) begin fails++; $display("FAIL rw_discard got en=%b iv=%b want 0/0", s_en, s_iv); end
    tick();
    tests++; if (s_en !== 1'b1 || s_addr !== 32'h1000 || s_iv !== 1'b0) begin fails++; $display("FAIL rw_reissue got en=%b addr=%h iv=%b want 1/1000/0", s_en, s_addr, s_iv); end
    n = 0;
    do begin tick(); n++; end while (!s_iv && n < 10);
    tests++; if (s_iv !== 1'b1 || s_ipc !== 32'h1000 || s_inst !== word_of(32'h1000)) begin fails++; $display("FAIL rw_first got iv=%b pc=%h inst=%h want 1/1000/%h", s_iv, s_ipc, s_inst, word_of(32'h1000)); end
  endtask
  task automatic test_redirect_accept();
    int n;
    settle(32'h8);
    ready = 1; iready = 1; mem_lat = 0;
    redirect = 1; redirect_address = 32'h2000;
    tick();
    tests++; if (s_en !== 1'b1 || s_addr !== 32'h8) begin fails++; $display("FAIL ra_accept got en=%b addr=%h want 1/8", s_en, s_addr); end
    redirect = 0;
    tick();
    tests++; if (s_en !== 1'b0 || s_iv !== 1'b0) begin fails++; $display("FAIL ra_discard got en=%b iv=%b want 0/0", s_en, s_iv); end
    tick();
    tests++; if (s_en !== 1'b1 || s_addr !== 32'h2000) begin fails++; $display("FAIL ra_reissue got en=%b addr=%h want 1/2000", s_en, s_addr); end
    n = 0;
    do begin tick(); n++; end while (!s_iv && n < 10);
    tests++; if (s_iv !== 1'b1 || s_ipc !== 32'h2000) begin fails++; $display("FAIL ra_first got iv=%b pc=%h want 1/2000", s_iv, s_ipc); end
  endtask
  task automatic test_wrap();
    settle(32'hFFFF_FFFC);
    ready = 1; iready = 1; mem_lat = 0;
    tick();
    tests++; if (s_en !== 1'b1 || s_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_top got en=%b addr=%h want 1/fffffffc", s_en, s_addr); end
    tick(); tick();
    tests++; if (s_en !== 1'b1 || s_addr !== 32'h0 || s_ipc !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_zero got en=%b addr=%h pc=%h want 1/0/fffffffc", s_en, s_addr, s_ipc); end
  endtask
  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 3000; i++) begin
      ready = $urandom_range(0, 3) != 0;
      iready = $urandom_range(0, 2) != 0;
      redirect = $urandom_range(0, 15) == 0;
      redirect_address = $urandom;
      mem_lat = $urandom_range(0, 3);
      tick();
      tests++;
      if (s_en !== e_en || s_addr !== e_addr || s_iv !== e_iv || (e_iv && (s_ipc !== e_ipc || s_inst !== e_inst))) begin
        fails++;
        if (bad++ < 10) $display("FAIL rand_cycle%0d got en=%b addr=%h iv=%b pc=%h inst=%h want en=%b addr=%h iv=%b pc=%h inst=%h",
          i, s_en, s_addr, s_iv, s_ipc, s_inst, e_en, e_addr, e_iv, e_ipc, e_inst);
      end
    end
    redirect = 0;
  endtask
  task automatic test_async_reset();
    settle(32'h40);
    ready = 1; iready = 0; mem_lat = 3;
    for (int i = 0; i < 6; i++) tick();
    tests++; if (iv !== 1'b1 || ipc !== 32'h40) begin fails++; $display("FAIL ar_queued got iv=%b pc=%h want 1/40", iv, ipc); end
    #2 reset = 0;
    #1;
    tests++; if (en !== 1'b0 || iv !== 1'b0) begin fails++; $display("FAIL ar_async got en=%b iv=%b want 0/0", en, iv); end
    model_reset();
    @(negedge clk); @(negedge clk);
    reset = 1;
    tick();
    tests++; if (s_en !== 1'b1 || s_addr !== 32'h0) begin fails++; $display("FAIL ar_restart got en=%b addr=%h want 1/0", s_en, s_addr); end
  endtask
  initial begin
    test_reset();
    test_latency();
    test_backpressure();
    test_redirect_wait();
    test_redirect_accept();
    test_wrap();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Owns the program counter and drives the instruction-fetch memory interface: issues word-aligned READ requests, advances the PC by 4, and buffers returned words in a small instruction queue toward decode.
- Handles redirects from execute (branch/jump/trap), stale-response discard, and queue back-pressure.
- Sits between the core's instruction memory port and the decode stage; replaces the combinational fetch path as the fetch-stage sequencer.

Parameters:
- RESET_ADDRESS, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0).
- QUEUE_DEPTH, 2, instruction queue entries; power of two, >= 2.

Ports:
- clk  in  1  core clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- memory_interface_enable  out  1  request valid (`ENABLE/`DISABLE).
- memory_interface_state  out  1  always `READ.
- memory_interface_address  out  32  fetch address, bits [1:0] = 0.
- memory_interface_frame_mask  out  4  always 4'b1111.
- memory_interface_ready  in  1  request accepted this cycle when enable=1.
- memory_interface_valid  in  1  response word present (>=1 cycle after accept).
- memory_interface_data  in  32  response instruction word.
- redirect_valid  in  1  flush and restart fetch.
- redirect_address  in  32  new PC; bits [1:0] forced to 0.
- instruction_valid  out  1  queue head valid.
- instruction  out  32  queue head word.
- instruction_pc  out  32  address of queue head word.
- instruction_ready  in  1  decode pops head when valid & ready.

Behaviour:
- Reset (async assert, sync release): pc=RESET_ADDRESS, state=ISSUE, queue empty, all outputs 0 except state=`READ and frame_mask=4'b1111; memory_interface_address=RESET_ADDRESS.
- Address and frame mask never tri-state; address always equals pc register.
- At most one request outstanding.
- States:
  - ISSUE: enable=1 iff queue count < QUEUE_DEPTH (registered count; same-cycle pop not credited). On enable & ready: latch req_pc=pc, pc<=pc+4 (mod 2^32, wraps to 0), go WAIT. Address/enable held stable until accepted.
  - WAIT: enable=0. On valid: push {data, req_pc} into queue, go ISSUE.
  - DISCARD: enable=0. On valid: drop data, go ISSUE.
- Redirect (highest priority, any state):
  - pc<={redirect_address[31:2],2'b00}; queue flushed (count=0, same-cycle pop and push ignored).
  - ISSUE without accept this cycle -> ISSUE.
  - ISSUE with accept this cycle -> DISCARD (accepted request is stale).
  - WAIT without valid -> DISCARD; WAIT with valid this cycle -> response dropped, -> ISSUE.
  - DISCARD without valid -> DISCARD; with valid -> ISSUE.
- instruction_valid=0 the cycle after a redirect until a post-redirect word is pushed.
- Queue: registered FIFO. Head outputs are combinational from queue storage. Push and pop in the same cycle allowed (count unchanged), including when full. Word pushed in cycle N is visible at head in N+1 if the queue was empty.
- Latency: reset release -> enable in first cycle; ready=1 at cycle 0, valid at cycle 1 -> instruction_valid at cycle 2.
- Steady-state throughput: 1 word / 2 cycles with zero-wait memory.
- Reset mid-operation: any outstanding response after reset release is not tracked; the memory side is reset by the same signal.

Decomposition:
- Shared Defines.v: existing `ENABLE/`DISABLE/`READ; add state encodings `FETCH_ISSUE=2'd0, `FETCH_WAIT=2'd1, `FETCH_DISCARD=2'd2.
- One sub-module: fetch_queue (parameterised DEPTH, WIDTH=64 {pc, word}, push/pop/flush, count, head outputs).
- The PC +4 uses the existing Incrementer on pc[31:2].

Test Plan:
- Reset release, memory ready=1, valid 1 cycle later with data=32'h0000_0013 -> requests to 0x0,0x4,0x8; instruction_valid at cycle 2 with instruction_pc=0x0; pc increments by 4.
- instruction_ready=0, QUEUE_DEPTH=2 -> exactly 2 words queued (pc 0x0, 0x4), enable stays 0; raise ready -> pops in order, enable returns the cycle after count < 2.
- Redirect to 0x0000_1002 while in WAIT, valid arrives 2 cycles later -> response dropped, next request address 0x0000_1000, no stale instruction_valid.
- Redirect in same cycle as accept of 0x8 -> state DISCARD, response for 0x8 dropped, first delivered instruction_pc = redirect target.
- Redirect to 0xFFFF_FFFC -> fetches 0xFFFF_FFFC then 0x0000_0000 (wrap).
- Assert reset with one word queued and one outstanding -> instruction_valid=0 and enable=0 immediately (async); after release, first request at RESET_ADDRESS.
